dcache_ctrl: RTL and testbench

//  Sequencing controller for the direct-mapped data cache (16 sets x 4-word lines, 137-bit line = {V,tag[7:0],w3,w2,w1,w0}) in front of byte-wide data RAM.

---
 rtl/dcache_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped data cache sequencer: tag compare, 16-byte line refill on load miss, byte-wide write-through.
// Optional load hit/miss statistics are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int SET_WIDTH  = 4,
  parameter int LINE_WIDTH = 137
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_type,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [SET_WIDTH-1:0]  cache_idx,
  input  logic [LINE_WIDTH-1:0] cache_rline,
  output logic                  cache_we,
  output logic [LINE_WIDTH-1:0] cache_wline,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int OFF_WIDTH  = ADDR_WIDTH - TAG_WIDTH - SET_WIDTH;
  localparam int LINE_BYTES = 2**OFF_WIDTH;
  localparam int DATA_BITS  = 8 * LINE_BYTES;
  localparam int WOFF       = $clog2(DATA_WIDTH / 8);
  localparam int CNT_WIDTH  = (SET_WIDTH > OFF_WIDTH) ? SET_WIDTH : OFF_WIDTH;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_REFILL, S_FILL, S_WRITE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [1:0]             len_q, len_d;
  logic [DATA_BITS-9:0]   line_q, line_d;
  logic                   resp_valid_d;
  logic [DATA_WIDTH-1:0]  resp_rdata_d;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [SET_WIDTH-1:0]   req_set;
  logic                   hit;
  logic [ADDR_WIDTH-1:0]  st_addr;
  logic [1:0]             st_len;
  logic [DATA_BITS-1:0]   merged;
  logic [DATA_BITS-1:0]   fill_data;

  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_set   = req_addr[OFF_WIDTH +: SET_WIDTH];
  assign hit       = cache_rline[LINE_WIDTH-1] &&
                     (cache_rline[LINE_WIDTH-2 -: TAG_WIDTH] == req_tag);
  assign fill_data = {mem_rdata, line_q};

  // Store alignment: st_len holds the byte count minus one.
  always_comb begin
    st_addr = req_addr;
    st_len  = 2'd3;
    unique case (req_type)
      2'b01:   st_len = 2'd0;
      2'b10: begin
        st_len     = 2'd1;
        st_addr[0] = 1'b0;
      end
      default: st_addr[1:0] = 2'b00;
    endcase
  end

  always_comb begin
    int unsigned off;
    off    = int'(st_addr[OFF_WIDTH-1:0]);
    merged = cache_rline[DATA_BITS-1:0];
    for (int unsigned j = 0; j < LINE_BYTES; j++) begin
      if (j >= off && j <= off + int'(st_len))
        merged[8*j +: 8] = req_wdata[8*(j-off) +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      len_q      <= '0;
      line_q     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      len_q      <= len_d;
      line_q     <= line_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
    end
  end

  // Strobes are decoded from state, so they are also gated by rst_n to drop at once on reset.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    len_d        = len_q;
    line_d       = line_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    req_ready    = 1'b0;
    cache_idx    = '0;
    cache_we     = 1'b0;
    cache_wline  = '0;
    mem_addr     = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    if (rst_n) begin
      unique case (state_q)
        S_INIT: begin
          cache_we  = 1'b1;
          cache_idx = cnt_q[SET_WIDTH-1:0];
          if (cnt_q == CNT_WIDTH'(2**SET_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        S_IDLE: begin
          req_ready = 1'b1;
          cache_idx = req_set;
          if (req_valid) begin
            if (!req_we) begin
              if (hit) begin
                resp_valid_d = 1'b1;
                resp_rdata_d = cache_rline[DATA_WIDTH*int'(req_addr[WOFF +: OFF_WIDTH-WOFF]) +: DATA_WIDTH];
              end else begin
                addr_d  = req_addr;
                cnt_d   = '0;
                state_d = S_REFILL;
              end
            end else begin
              if (hit) begin
                cache_we    = 1'b1;
                cache_wline = {cache_rline[LINE_WIDTH-1 -: 1+TAG_WIDTH], merged};
              end
              addr_d  = st_addr;
              wdata_d = req_wdata;
              len_d   = st_len;
              cnt_d   = '0;
              state_d = S_WRITE;
            end
          end
        end
        S_REFILL: begin
          mem_re   = 1'b1;
          mem_addr = {addr_q[ADDR_WIDTH-1:OFF_WIDTH], cnt_q[OFF_WIDTH-1:0]};
          if (cnt_q != '0)
            line_d[8*(int'(cnt_q)-1) +: 8] = mem_rdata;
          if (cnt_q == CNT_WIDTH'(LINE_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        S_FILL: begin
          cache_we     = 1'b1;
          cache_idx    = addr_q[OFF_WIDTH +: SET_WIDTH];
          cache_wline  = {1'b1, addr_q[ADDR_WIDTH-1 -: TAG_WIDTH], fill_data};
          resp_valid_d = 1'b1;
          resp_rdata_d = fill_data[DATA_WIDTH*int'(addr_q[WOFF +: OFF_WIDTH-WOFF]) +: DATA_WIDTH];
          state_d      = S_IDLE;
        end
        S_WRITE: begin
          mem_we    = 1'b1;
          mem_addr  = addr_q + ADDR_WIDTH'(cnt_q);
          mem_wdata = wdata_q[8*int'(cnt_q[1:0]) +: 8];
          if (cnt_q == CNT_WIDTH'(len_q)) begin
            cnt_d        = '0;
            resp_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        ld_acc;
  logic [15:0] hit_q, miss_q;

  assign ld_acc = (state_q == S_IDLE) && req_valid && !req_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (ld_acc) begin
      if (hit && hit_q != '1)
        hit_q <= hit_q + 16'd1;
      if (!hit && miss_q != '1)
        miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: the environment holds the cache array and RAM; the model predicts
// load data from a flat byte memory and hit/miss timing from a per-set valid/tag table.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [15:0]  req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic [1:0]   req_type = '0;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic [3:0]   cache_idx;
  logic [136:0] cache_rline;
  logic         cache_we;
  logic [136:0] cache_wline;
  logic [15:0]  mem_addr;
  logic         mem_re;
  logic [7:0]   mem_rdata;
  logic         mem_we;
  logic [7:0]   mem_wdata;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  always #5 clk = ~clk;

  dcache_ctrl #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .TAG_WIDTH (8),
    .SET_WIDTH (4),
    .LINE_WIDTH(137)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_type   (req_type),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .cache_idx  (cache_idx),
    .cache_rline(cache_rline),
    .cache_we   (cache_we),
    .cache_wline(cache_wline),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // Environment: cache array with combinational read, byte RAM with one-cycle read.
  logic [136:0] carr [16];
  logic [7:0]   ram  [65536];
  logic [7:0]   rd_q = '0;

  assign cache_rline = carr[cache_idx];
  assign mem_rdata   = rd_q;

  always @(posedge clk) begin
    if (cache_we) carr[cache_idx] <= cache_wline;
    if (mem_re)   rd_q <= ram[mem_addr];
    if (mem_we)   ram[mem_addr] <= mem_wdata;
  end

  // Reference model
  logic [7:0]  ref_mem [65536];
  logic        mv [16];
  logic [7:0]  mt [16];
  int unsigned m_hits = 0, m_misses = 0;
  int          vectors = 0, miscompares = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]  data;
    int           lat;
    int           acc;
    int           n_re;
    int           n_we;
    bit           chk_line;
    logic [3:0]   set;
    logic [136:0] line;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   re_cnt = 0, we_cnt = 0;

  task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [136:0] ref_line(input logic [7:0] tag, input logic [3:0] set);
    logic [136:0] l;
    l = '0;
    l[136] = 1'b1;
    l[135:128] = tag;
    for (int j = 0; j < 16; j++) l[8*j +: 8] = ref_mem[{tag, set, 4'(j)}];
    return l;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no outstanding request");
        end else begin
          mon_e = sb.pop_front();
          chk("rdata", 137'(resp_rdata), 137'(mon_e.data));
          chk("latency", 137'(cyc - mon_e.acc), 137'(mon_e.lat));
          chk("mem_re_count", 137'(re_cnt), 137'(mon_e.n_re));
          chk("mem_we_count", 137'(we_cnt), 137'(mon_e.n_we));
          if (mon_e.chk_line) chk("fill_line", carr[mon_e.set], mon_e.line);
        end
        re_cnt = 0;
        we_cnt = 0;
      end else begin
        re_cnt += int'(mem_re);
        we_cnt += int'(mem_we);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the transfer edge.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] wd, input logic [1:0] typ);
    exp_t       e;
    int         n;
    bit         ok;
    logic [15:0] a, wa;
    logic [3:0] set;
    logic [7:0] tag;
    bit         hit;
    n  = (typ == 2'b01) ? 1 : (typ == 2'b10) ? 2 : 4;
    a  = addr;
    if (n == 4) a[1:0] = 2'b00;
    else if (n == 2) a[0] = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_type  = typ;
    ok = 0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got req_ready=0 for 200 cycles expected 1");
      req_valid = 1'b0;
      return;
    end
    set = addr[7:4];
    tag = addr[15:8];
    hit = mv[set] && (mt[set] == tag);
    e.acc = cyc;
    e.set = set;
    if (!we) begin
      wa = {addr[15:2], 2'b00};
      e.data = {ref_mem[wa + 16'd3], ref_mem[wa + 16'd2], ref_mem[wa + 16'd1], ref_mem[wa]};
      e.lat  = hit ? 1 : 18;
      e.n_re = hit ? 0 : 16;
      e.n_we = 0;
      e.chk_line = !hit;
      e.line = ref_line(tag, set);
      chk("load_cache_we", 137'(cache_we), 137'(0));
      if (hit) m_hits++;
      else begin
        m_misses++;
        mv[set] = 1'b1;
        mt[set] = tag;
      end
    end else begin
      for (int i = 0; i < n; i++) ref_mem[a + 16'(i)] = wd[8*i +: 8];
      e.data = '0;
      e.lat  = n + 1;
      e.n_re = 0;
      e.n_we = n;
      e.chk_line = 0;
      e.line = '0;
      chk("store_cache_we", 137'(cache_we), 137'(hit));
      if (hit) chk("store_wline", cache_wline, ref_line(tag, set));
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int w = 0; w < 200 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  logic [7:0]  tg [4];
  logic [15:0] ra;
  int          cnt;
  bit          found;

  initial begin
    tg[0] = 8'h12; tg[1] = 8'h34; tg[2] = 8'h55; tg[3] = 8'hA7;
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    for (int j = 0; j < 16; j++) begin
      ram[16'h1230 + j]     = 8'(j);
      ref_mem[16'h1230 + j] = 8'(j);
    end
    for (int s = 0; s < 16; s++) begin
      mv[s] = 1'b0;
      mt[s] = '0;
      carr[s] = {1'b1, 8'h12, 128'($urandom)};
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", 137'({req_ready, resp_valid, cache_we, mem_re, mem_we}), 137'(0));
    chk("rst_resp_rdata", 137'(resp_rdata), 137'(0));
    chk("rst_wline", cache_wline, 137'(0));
    chk("rst_mem_bus", 137'({mem_addr, mem_wdata}), 137'(0));
    chk("rst_counters", 137'({hit_count, miss_count}), 137'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("init_we", 137'(cache_we), 137'(1));
      chk("init_idx", 137'(cache_idx), 137'(i));
      chk("init_wline", cache_wline, 137'(0));
      chk("init_ready", 137'(req_ready), 137'(0));
    end
    @(negedge clk);
    chk("ready_after_init", 137'(req_ready), 137'(1));
    @(posedge clk);
    #1;

    issue(1'b0, 16'h1234, 32'h0, 2'b00);
    issue(1'b0, 16'h1238, 32'h0, 2'b00);
    issue(1'b1, 16'h1239, 32'h000000AB, 2'b01);
    issue(1'b0, 16'h1238, 32'h0, 2'b00);
    issue(1'b1, 16'h5502, 32'hDEADBEEF, 2'b00);
    wait_idle();
    chk("ram_word_5500", 137'({ram[16'h5503], ram[16'h5502], ram[16'h5501], ram[16'h5500]}), 137'(32'hDEADBEEF));
    chk("ram_byte_1239", 137'(ram[16'h1239]), 137'(8'hAB));

    // Reset in the middle of a refill
    issue(1'b0, 16'h7710, 32'h0, 2'b00);
    found = 0;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (mem_re && mem_addr[3:0] == 4'd8) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL refill_k8: got no mem_re at offset 8 expected one within 40 cycles");
    end
    #1 rst_n = 1'b0;
    #1;
    chk("abort_strobes", 137'({req_ready, resp_valid, cache_we, mem_re, mem_we}), 137'(0));
    chk("abort_bus", 137'({mem_addr, mem_wdata, resp_rdata}), 137'(0));
    sb.delete();
    re_cnt = 0;
    we_cnt = 0;
    m_hits = 0;
    m_misses = 0;
    for (int s = 0; s < 16; s++) mv[s] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      cnt++;
      if (req_ready) break;
    end
    chk("reinit_cycles", 137'(cnt), 137'(17));
    @(posedge clk);
    #1;
    issue(1'b0, 16'h7710, 32'h0, 2'b00);
    issue(1'b0, 16'h7714, 32'h0, 2'b00);
    wait_idle();

    for (int t = 0; t < 300; t++) begin
      ra = {tg[$urandom_range(0, 3)], 4'($urandom_range(0, 3)), 4'($urandom)};
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(($urandom_range(0, 2) == 0), ra, $urandom, 2'($urandom));
    end
    wait_idle();

`ifdef DCACHE_STATS_EN
    chk("hit_count", 137'(hit_count), 137'((m_hits > 65535) ? 65535 : m_hits));
    chk("miss_count", 137'(miss_count), 137'((m_misses > 65535) ? 65535 : m_misses));
`else
    chk("hit_count", 137'(hit_count), 137'(0));
    chk("miss_count", 137'(miss_count), 137'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
